hazard_forwarding_unit: RTL
===========================

# hazard_forwarding_unit

- Parametrised hazard unit for the 5-stage pipeline CPU, sitting beside the ID/EX stage.
- Combines operand forwarding (EX/MEM and MEM/WB to EX) with load-use stall control and branch flush control.
- Adds a configurable multi-cycle load-use stall for slow data memory, flush-over-stall priority, and saturating performance counters.
- Drives the PC, IF/ID and ID/EX control pins directly.

## Interface

Parameters:
- REG_ADDR_W, 5, register index width; index 0 is the hard-wired zero register.
- LOAD_LATENCY, 1, total stall cycles per load-use hazard; legal range 1..8.
- CNT_W, 16, width of each performance counter.

Ports (reset is asynchronous and active-low):
- clk_i  in  1  pipeline clock.
- rst_n_i  in  1  asynchronous active-low reset.
- id_ex_register_rs1_i / id_ex_register_rs2_i  in  REG_ADDR_W  source registers of the instruction in EX.
- ex_mem_regwrite_wb_i  in  1  EX/MEM instruction writes the register file.
- ex_mem_register_rd_i  in  REG_ADDR_W  EX/MEM destination register.
- mem_wb_regwrite_wb_i  in  1  MEM/WB instruction writes the register file.
- mem_wb_register_rd_i  in  REG_ADDR_W  MEM/WB destination register.
- id_ex_memread_i  in  1  instruction in EX is a load.
- id_ex_register_rd_i  in  REG_ADDR_W  destination register of the instruction in EX.
- if_id_register_rs1_i / if_id_register_rs2_i  in  REG_ADDR_W  sources of the instruction in ID.
- branch_taken_i  in  1  branch or jump resolved taken in EX.
- cnt_clr_i  in  1  synchronous clear of both counters.
- forwardA_o / forwardB_o  out  2  operand select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID load enable.
- id_ex_bubble_o  out  1  zero the control bits entering ID/EX.
- if_id_flush_o  out  1  replace the IF/ID contents with a NOP.
- stall_cnt_o  out  CNT_W  number of cycles with pc_write_o=0.
- flush_cnt_o  out  CNT_W  number of cycles with if_id_flush_o=1.

## Operation

Forwarding (combinational, evaluated independently per operand X ∈ {rs1, rs2}):
- Select 10 if ex_mem_regwrite_wb_i, ex_mem rd≠0 and ex_mem rd==X.
- Otherwise select 01 if mem_wb_regwrite_wb_i, mem_wb rd≠0 and mem_wb rd==X.
- Otherwise select 00.
- forwardA_o and forwardB_o are always both driven; each operand is decided independently of the other.

Load-use hazard:
- hz = id_ex_memread_i && id_ex_rd≠0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).

FSM states:
- IDLE: the default state.
- STALL: holds a down-counter scnt of width ceil(log2(8)).

FSM transitions and outputs:
- IDLE with hz and no branch: assert the stall outputs (pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1) in the same cycle.
  - If LOAD_LATENCY>1, go to STALL with scnt=LOAD_LATENCY-2.
  - Otherwise stay in IDLE.
- STALL: keep the stall outputs asserted. Go to IDLE when scnt==0; otherwise decrement scnt.
- branch_taken_i in any state forces if_id_flush_o=1, id_ex_bubble_o=1 and pc_write_o=1, and sets next state to IDLE.
  - Flush wins over hz and aborts any stall in progress.
- Otherwise: pc_write_o=1, if_id_write_o=1, id_ex_bubble_o=0, if_id_flush_o=0.

Counters:
- Each counter increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
- cnt_clr_i has priority over increment; the counter reads 0 the next cycle.

## Timing

- Forwarding, stall and flush outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- A load-use stall lasts exactly LOAD_LATENCY cycles, counted from the detection cycle.
- A flush lasts exactly as many cycles as branch_taken_i is high.
- Counters update on the rising clk_i edge after the qualifying cycle.
- Reset values: state IDLE, scnt 0, stall_cnt_o 0, flush_cnt_o 0.
  - With inputs idle, the outputs are pc_write_o=1, if_id_write_o=1, id_ex_bubble_o=0, if_id_flush_o=0, forwardA_o=forwardB_o=00.
- Reset asserted mid-stall returns to IDLE immediately; the stall outputs deassert asynchronously.

## Structure

- hazard_pkg contains:
  - fwd_sel_e: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - hz_state_e: IDLE, STALL.
  - the MAX_LOAD_LATENCY=8 constant.
- Sub-module fwd_select: one operand's priority mux decision, instantiated twice (rs1, rs2).
- FSM and counters live in the top level.

## Test plan

- EX/MEM and MEM/WB both write x5; id_ex rs1=5, rs2=5 -> forwardA_o=10, forwardB_o=10.
- Only MEM/WB writes x7, rs2=7; EX/MEM writes x0 -> forwardA_o=00, forwardB_o=01. Writes to rd=0 never forward.
- Load to x3 in EX with ID rs1=3, LOAD_LATENCY=3 -> pc_write_o=0 for exactly 3 cycles; stall_cnt_o=3 afterwards.
- Load-use hazard and branch_taken_i in the same cycle -> if_id_flush_o=1, pc_write_o=1, no stall; flush_cnt_o +1.
- Stall in cycle 2 of 3, then branch_taken_i -> stall aborted, state IDLE next cycle.
- Force stall_cnt_o to all-ones -> holds at all-ones; then cnt_clr_i -> 0.
- rst_n_i low mid-stall -> all outputs at reset values, both counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Purpose: Shared types and constants for the pipeline hazard/forwarding unit.
//          - fwd_sel_e  : operand-select encoding driven onto forwardA/forwardB
//          - hz_state_e : load-use stall controller states
//          - MAX_LOAD_LATENCY / SCNT_W : bounds of the stall down-counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from register file
    FWD_WB  = 2'b01,  // operand from MEM/WB result
    FWD_MEM = 2'b10   // operand from EX/MEM result
  } fwd_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int MAX_LOAD_LATENCY = 8;

  // Width of the stall down-counter; LOAD_LATENCY-2 never exceeds 6.
  localparam int SCNT_W = $clog2(MAX_LOAD_LATENCY);

endpackage

`default_nettype wire

// File: rtl/hazard_forwarding_unit_fwd_select.sv
// ============================================================================
// Module : fwd_select
// Purpose: Forwarding decision for a single EX-stage source operand.
//          The youngest producer (EX/MEM) wins over MEM/WB; writes to the
//          hard-wired zero register never forward.
// Ports  : ex_mem_regwrite / ex_mem_rd  - EX/MEM producer
//          mem_wb_regwrite / mem_wb_rd  - MEM/WB producer
//          src                          - operand register index
//          sel                          - resulting operand select
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  mem_wb_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [REG_ADDR_W-1:0] src,
  output fwd_sel_e              sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == src);
  assign wb_hit  = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_forwarding_unit.sv
// ============================================================================
// Module : hazard_forwarding_unit
// Purpose: Hazard unit beside the ID/EX stage of a 5-stage pipeline.
//          - operand forwarding (EX/MEM, MEM/WB -> EX) per source operand
//          - load-use stall lasting LOAD_LATENCY cycles (1..8)
//          - branch flush, which overrides and aborts any stall
//          - saturating stall / flush cycle counters with synchronous clear
// Ports  : clk_i, rst_n_i (async active-low)
//          id_ex_register_rs1_i/rs2_i/rd_i, id_ex_memread_i  - EX instruction
//          ex_mem_regwrite_wb_i, ex_mem_register_rd_i        - EX/MEM
//          mem_wb_regwrite_wb_i, mem_wb_register_rd_i        - MEM/WB
//          if_id_register_rs1_i/rs2_i                        - ID instruction
//          branch_taken_i, cnt_clr_i
//          forwardA_o/forwardB_o, pc_write_o, if_id_write_o,
//          id_ex_bubble_o, if_id_flush_o, stall_cnt_o, flush_cnt_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rs2_i,
  input  logic                  ex_mem_regwrite_wb_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_register_rd_i,
  input  logic                  mem_wb_regwrite_wb_i,
  input  logic [REG_ADDR_W-1:0] mem_wb_register_rd_i,
  input  logic                  id_ex_memread_i,
  input  logic [REG_ADDR_W-1:0] id_ex_register_rd_i,
  input  logic [REG_ADDR_W-1:0] if_id_register_rs1_i,
  input  logic [REG_ADDR_W-1:0] if_id_register_rs2_i,
  input  logic                  branch_taken_i,
  input  logic                  cnt_clr_i,
  output logic [1:0]            forwardA_o,
  output logic [1:0]            forwardB_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  id_ex_bubble_o,
  output logic                  if_id_flush_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // The detection cycle is the first stall cycle, so STALL covers the
  // remaining LOAD_LATENCY-1 cycles: it starts at LOAD_LATENCY-2 and exits
  // after the cycle in which it reads zero.
  localparam logic [SCNT_W-1:0] SCNT_INIT =
    SCNT_W'((LOAD_LATENCY > 1) ? (LOAD_LATENCY - 2) : 0);

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .ex_mem_regwrite (ex_mem_regwrite_wb_i),
    .ex_mem_rd       (ex_mem_register_rd_i),
    .mem_wb_regwrite (mem_wb_regwrite_wb_i),
    .mem_wb_rd       (mem_wb_register_rd_i),
    .src             (id_ex_register_rs1_i),
    .sel             (sel_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .ex_mem_regwrite (ex_mem_regwrite_wb_i),
    .ex_mem_rd       (ex_mem_register_rd_i),
    .mem_wb_regwrite (mem_wb_regwrite_wb_i),
    .mem_wb_rd       (mem_wb_register_rd_i),
    .src             (id_ex_register_rs2_i),
    .sel             (sel_b)
  );

  assign forwardA_o = sel_a;
  assign forwardB_o = sel_b;

  // --------------------------------------------------------------------------
  // Load-use detection
  // --------------------------------------------------------------------------
  logic hz;

  assign hz = id_ex_memread_i && (id_ex_register_rd_i != '0) &&
              ((id_ex_register_rd_i == if_id_register_rs1_i) ||
               (id_ex_register_rd_i == if_id_register_rs2_i));

  // --------------------------------------------------------------------------
  // Stall / flush controller
  // --------------------------------------------------------------------------
  hz_state_e         state_q, state_d;
  logic [SCNT_W-1:0] scnt_q,  scnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    scnt_d         = scnt_q;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;

    if (branch_taken_i) begin
      // Flush overrides a fresh hazard and aborts a stall in progress.
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      pc_write_o     = 1'b1;
      state_d        = IDLE;
      scnt_d         = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_d = STALL;
              scnt_d  = SCNT_INIT;
            end
          end
        end
        STALL: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          if (scnt_q == '0) begin
            state_d = IDLE;
          end else begin
            scnt_d = scnt_q - SCNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          scnt_d  = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters (clear beats increment)
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

`default_nettype wire
